// File: rtl/pattern_stepper.sv
// Steps a test-pattern index on debounced button presses, with frame-based
// auto-repeat while held; the index reaches the pattern generator only at frame end.
module pattern_stepper #(
    parameter int H_TOTAL       = 1056,
    parameter int V_TOTAL       = 628,
    parameter int NUM_PAT       = 8,
    parameter int PAT_W         = 4,
    parameter int HOLD_FRAMES   = 30,
    parameter int REPEAT_FRAMES = 6
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Step_Pulse,
    input  logic             Botten_Level,
    input  logic [15:0]      Pixel_Cnt,
    input  logic [15:0]      Line_Cnt,
    output logic [PAT_W-1:0] Pattern_Sel,
    output logic             Pattern_Chg,
    output logic             Repeat_Active
);

    localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam int REP_W  = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;

    localparam logic [PAT_W-1:0]  PAT_LAST  = PAT_W'(NUM_PAT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        REPEAT
    } state_t;

    state_t            state_q, state_d;
    logic [PAT_W-1:0]  pat_next_q, pat_next_d;
    logic [PAT_W-1:0]  pattern_sel_q, pattern_sel_d;
    logic              pattern_chg_q, pattern_chg_d;
    logic              repeat_active_q, repeat_active_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;

    logic              frame_end;
    logic [PAT_W-1:0]  pat_inc;

    assign frame_end = (Pixel_Cnt == 16'(H_TOTAL - 1)) && (Line_Cnt == 16'(V_TOTAL - 1));

    // Explicit wrap so a NUM_PAT below 2**PAT_W never walks into unused indices.
    assign pat_inc = (pat_next_q == PAT_LAST) ? '0 : pat_next_q + PAT_W'(1);

    // Commit path: compares against the pre-edge pat_next, so a step taken on
    // a frame-end edge is only seen by the following frame end.
    always_comb begin
        // NOTE: every signal written here gets a default first; a missed branch would otherwise infer a latch.
        pattern_sel_d = pattern_sel_q;
        pattern_chg_d = 1'b0;
        if (frame_end && (pattern_sel_q != pat_next_q)) begin
            pattern_sel_d = pat_next_q;
            pattern_chg_d = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        pat_next_d = pat_next_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;

        case (state_q)
            IDLE: begin
                if (Step_Pulse) begin
                    pat_next_d = pat_inc;
                    hold_cnt_d = '0;
                    state_d    = HELD;
                end
            end
            HELD: begin
                if (frame_end) begin
                    if (!Botten_Level) begin
                        state_d = IDLE;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        rep_cnt_d = '0;
                        state_d   = REPEAT;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
            end
            REPEAT: begin
                if (frame_end) begin
                    if (!Botten_Level) begin
                        state_d = IDLE;
                    end else if (rep_cnt_q == REP_LAST) begin
                        pat_next_d = pat_inc;
                        rep_cnt_d  = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        repeat_active_d = (state_d == REPEAT);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        // NOTE: flops use non-blocking assignments so each one samples values from before the edge.
        if (!Reset) begin
            state_q         <= IDLE;
            pat_next_q      <= '0;
            pattern_sel_q   <= '0;
            pattern_chg_q   <= 1'b0;
            repeat_active_q <= 1'b0;
            hold_cnt_q      <= '0;
            rep_cnt_q       <= '0;
        end else begin
            state_q         <= state_d;
            pat_next_q      <= pat_next_d;
            pattern_sel_q   <= pattern_sel_d;
            pattern_chg_q   <= pattern_chg_d;
            repeat_active_q <= repeat_active_d;
            hold_cnt_q      <= hold_cnt_d;
            rep_cnt_q       <= rep_cnt_d;
        end
    end

    assign Pattern_Sel   = pattern_sel_q;
    assign Pattern_Chg   = pattern_chg_q;
    assign Repeat_Active = repeat_active_q;

endmodule

// File: tb/tb_pattern_stepper.sv
// Bench for pattern_stepper: directed scenarios with literal expectations plus a
// randomized phase, all outputs compared every cycle against a frame-level model.
module tb_pattern_stepper;

    localparam int H_T  = 8;
    localparam int V_T  = 4;
    localparam int NPAT = 4;
    localparam int HOLD = 3;
    localparam int REP  = 2;
    localparam int FRAME = H_T * V_T;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Step_Pulse = 1'b0;
    logic        Botten_Level = 1'b0;
    logic [15:0] Pixel_Cnt;
    logic [15:0] Line_Cnt;
    logic [3:0]  Pattern_Sel;
    logic        Pattern_Chg;
    logic        Repeat_Active;

    int n_checks = 0;
    int n_err    = 0;

    // Model: press count k = frame ends survived while held since the press.
    int m_sel    = 0;
    int m_pnext  = 0;
    int m_k      = 0;
    bit m_active = 1'b0;
    bit m_chg    = 1'b0;

    pattern_stepper #(
        .H_TOTAL(H_T), .V_TOTAL(V_T), .NUM_PAT(NPAT), .PAT_W(4),
        .HOLD_FRAMES(HOLD), .REPEAT_FRAMES(REP)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Step_Pulse(Step_Pulse),
        .Botten_Level(Botten_Level),
        .Pixel_Cnt(Pixel_Cnt),
        .Line_Cnt(Line_Cnt),
        .Pattern_Sel(Pattern_Sel),
        .Pattern_Chg(Pattern_Chg),
        .Repeat_Active(Repeat_Active)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit fe_now();
        return (Pixel_Cnt == 16'(H_T - 1)) && (Line_Cnt == 16'(V_T - 1));
    endfunction

    function automatic int inc_f(input int x);
        return (x + 1) % NPAT;
    endfunction

    function automatic bit m_repeat();
        return m_active && (m_k >= HOLD);
    endfunction

    // Free-running timing generator, unaffected by Reset.
    initial begin
        Pixel_Cnt = '0;
        Line_Cnt  = '0;
        forever begin
            @(posedge Clock);
            #1;
            if (Pixel_Cnt == 16'(H_T - 1)) begin
                Pixel_Cnt = '0;
                Line_Cnt  = (Line_Cnt == 16'(V_T - 1)) ? 16'd0 : Line_Cnt + 16'd1;
            end else begin
                Pixel_Cnt = Pixel_Cnt + 16'd1;
            end
        end
    end

    initial begin
        forever begin
            @(posedge Clock or negedge Reset);
            if (!Reset) begin
                m_sel = 0; m_pnext = 0; m_k = 0; m_active = 1'b0; m_chg = 1'b0;
            end else begin
                automatic bit fe = (Pixel_Cnt == 16'(H_T - 1)) && (Line_Cnt == 16'(V_T - 1));
                m_chg = 1'b0;
                if (fe && (m_sel != m_pnext)) begin
                    m_sel = m_pnext;
                    m_chg = 1'b1;
                end
                if (!m_active) begin
                    if (Step_Pulse) begin
                        m_pnext  = inc_f(m_pnext);
                        m_active = 1'b1;
                        m_k      = 0;
                    end
                end else if (fe) begin
                    if (!Botten_Level) begin
                        m_active = 1'b0;
                    end else begin
                        m_k++;
                        if ((m_k > HOLD) && (((m_k - HOLD) % REP) == 0))
                            m_pnext = inc_f(m_pnext);
                    end
                end
            end
        end
    end

    always @(negedge Clock) begin
        if (Reset === 1'b1) begin
            check("sel", 32'(Pattern_Sel), 32'(m_sel));
            check("chg", 32'(Pattern_Chg), 32'(m_chg));
            check("repeat_active", 32'(Repeat_Active), 32'(m_repeat()));
        end
    end

    task automatic next_cycle();
        @(posedge Clock);
        #2;
    endtask

    task automatic goto_fe();
        int n = 0;
        while (!fe_now() && n < 2 * FRAME) begin
            next_cycle();
            n++;
        end
        if (!fe_now()) begin
            n_checks++;
            n_err++;
            $display("FAIL fe_timeout: got 0 expected 1 at %0t", $time);
        end
    endtask

    task automatic do_reset();
        Step_Pulse   = 1'b0;
        Botten_Level = 1'b0;
        Reset        = 1'b0;
        repeat (2) next_cycle();
        Reset = 1'b1;
    endtask

    // Press with the level held for the press frame only, then wait for the commit.
    task automatic single_press(input int exp_sel, input string name);
        goto_fe();
        Step_Pulse   = 1'b1;
        Botten_Level = 1'b1;
        next_cycle();
        Step_Pulse   = 1'b0;
        Botten_Level = 1'b0;
        goto_fe();
        next_cycle();
        check(name, 32'(Pattern_Sel), 32'(exp_sel));
        check({name, "_chg"}, 32'(Pattern_Chg), 32'd1);
    endtask

    int s3_exp[4]  = '{1, 2, 3, 0};
    int s4_exp[10] = '{1, 1, 1, 1, 1, 2, 2, 3, 3, 0};

    initial begin
        // 1: reset, then idle for three frames
        repeat (3) next_cycle();
        Reset = 1'b1;
        repeat (3) begin
            goto_fe();
            next_cycle();
        end
        check("s1_sel", 32'(Pattern_Sel), 32'd0);
        check("s1_chg", 32'(Pattern_Chg), 32'd0);
        check("s1_ra", 32'(Repeat_Active), 32'd0);
        check("s1_model_sel", 32'(m_sel), 32'd0);

        // 2: step at frame end, level held one frame; commit one frame later
        goto_fe();
        Step_Pulse   = 1'b1;
        Botten_Level = 1'b1;
        next_cycle();
        Step_Pulse = 1'b0;
        check("s2_no_early", 32'(Pattern_Sel), 32'd0);
        goto_fe();
        next_cycle();
        check("s2_sel", 32'(Pattern_Sel), 32'd1);
        check("s2_chg", 32'(Pattern_Chg), 32'd1);
        check("s2_model_sel", 32'(m_sel), 32'd1);
        Botten_Level = 1'b0;
        next_cycle();
        check("s2_chg_one_clk", 32'(Pattern_Chg), 32'd0);
        repeat (2) begin
            goto_fe();
            next_cycle();
        end
        check("s2_sel_stable", 32'(Pattern_Sel), 32'd1);

        // 3: four single presses wrap 1,2,3,0
        do_reset();
        for (int i = 0; i < 4; i++) single_press(s3_exp[i], $sformatf("s3_sel%0d", i));

        // 4: press held for ten frame ends
        do_reset();
        goto_fe();
        Step_Pulse   = 1'b1;
        Botten_Level = 1'b1;
        next_cycle();
        Step_Pulse = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            goto_fe();
            next_cycle();
            check($sformatf("s4_sel_k%0d", k), 32'(Pattern_Sel), 32'(s4_exp[k-1]));
            check($sformatf("s4_ra_k%0d", k), 32'(Repeat_Active), (k >= HOLD) ? 32'd1 : 32'd0);
        end
        check("s4_model_sel", 32'(m_sel), 32'd0);

        // 5: reset while repeating with pat_next=2
        do_reset();
        goto_fe();
        Step_Pulse   = 1'b1;
        Botten_Level = 1'b1;
        next_cycle();
        Step_Pulse = 1'b0;
        repeat (5) begin
            goto_fe();
            next_cycle();
        end
        check("s5_model_pnext", 32'(m_pnext), 32'd2);
        check("s5_ra_before", 32'(Repeat_Active), 32'd1);
        check("s5_sel_before", 32'(Pattern_Sel), 32'd1);
        repeat (5) next_cycle();
        Reset = 1'b0;
        #1;
        check("s5_sel_in_reset", 32'(Pattern_Sel), 32'd0);
        check("s5_ra_in_reset", 32'(Repeat_Active), 32'd0);
        check("s5_chg_in_reset", 32'(Pattern_Chg), 32'd0);
        repeat (2) next_cycle();
        Reset        = 1'b1;
        Botten_Level = 1'b0;
        repeat (2) begin
            goto_fe();
            next_cycle();
            check("s5_no_chg", 32'(Pattern_Chg), 32'd0);
        end
        check("s5_sel_after", 32'(Pattern_Sel), 32'd0);

        // 6: step pulse while HELD is ignored
        do_reset();
        goto_fe();
        Step_Pulse   = 1'b1;
        Botten_Level = 1'b1;
        next_cycle();
        Step_Pulse = 1'b0;
        goto_fe();
        Step_Pulse = 1'b1;
        next_cycle();
        Step_Pulse   = 1'b0;
        Botten_Level = 1'b0;
        check("s6_sel", 32'(Pattern_Sel), 32'd1);
        repeat (2) begin
            goto_fe();
            next_cycle();
        end
        check("s6_sel_unchanged", 32'(Pattern_Sel), 32'd1);
        check("s6_model_pnext", 32'(m_pnext), 32'd1);

        // Random phase: mostly-held levels changed at frame end, steps mostly frame-aligned
        do_reset();
        for (int c = 0; c < 40 * FRAME; c++) begin
            next_cycle();
            if (c == 700) begin
                Reset = 1'b0;
                repeat (2) next_cycle();
                Reset = 1'b1;
            end
            if (fe_now()) begin
                Botten_Level = ($urandom_range(5) != 0);
                Step_Pulse   = ($urandom_range(2) == 0);
            end else begin
                Step_Pulse = ($urandom_range(63) == 0);
            end
        end
        Step_Pulse   = 1'b0;
        Botten_Level = 1'b0;
        repeat (4) next_cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
